// File: rtl/maxnet_term_pkg.sv
// Shared types for the MaxNet termination controller.
// Build option: STALL_DETECT_EN adds stall detection (status 3).
package maxnet_term_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_WIN      = 2'd0,
    ST_ALL_ZERO = 2'd1,
    ST_TIMEOUT  = 2'd2,
    ST_STALL    = 2'd3
  } status_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/maxnet_onehot_enc.sv
// Classifies the alive mask: one-hot, all-zero and lowest set index.
// Purely combinational.
module maxnet_onehot_enc
  import maxnet_term_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  alive,
  output logic          is_onehot,
  output logic          is_zero,
  output logic [IW-1:0] lowest_idx
);

  assign is_zero   = ~|alive;
  assign is_onehot = $onehot(alive);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    lowest_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (alive[i]) lowest_idx = IW'(i);
  end

endmodule

// File: rtl/maxnet_term_ctrl.sv
// MaxNet winner-take-all termination controller.
// Build option: STALL_DETECT_EN enables repeated-mask stall detection.
module maxnet_term_ctrl
  import maxnet_term_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int MAX_IT  = 64,
  parameter int STALL_K = 8,
  localparam int IW  = clog2(N),
  localparam int ITW = clog2(MAX_IT + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           in_valid,
  input  logic [N*W-1:0] x_bus,
  input  logic [N-1:0]   alive,
  output logic           busy,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [IW-1:0]  win_idx,
  output logic [W-1:0]   win_val,
  output logic [1:0]     status,
  output logic [ITW-1:0] iter_cnt
);

  state_t         state_q, state_d;
  status_t        st_q, st_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   val_q, val_d;
  logic [ITW-1:0] iter_q, iter_nxt;

  logic           is_onehot, is_zero;
  logic [IW-1:0]  low_idx;
  logic [W-1:0]   low_val;
  logic           sample, fin, to_hit, stall_hit;

  maxnet_onehot_enc #(.N(N)) u_enc (
    .alive      (alive),
    .is_onehot  (is_onehot),
    .is_zero    (is_zero),
    .lowest_idx (low_idx)
  );

  assign sample   = (state_q == RUN) && in_valid;
  assign iter_nxt = iter_q + ITW'(1);
  assign to_hit   = (iter_nxt == ITW'(MAX_IT));
  assign low_val  = x_bus[low_idx*W +: W];

`ifdef STALL_DETECT_EN
  localparam int SW = clog2(STALL_K + 1);

  logic [N-1:0]  last_q;
  logic [SW-1:0] rep_q, rep_d;

  always_comb begin
    rep_d = '0;
    if (alive == last_q)
      rep_d = (rep_q == SW'(STALL_K)) ? rep_q : rep_q + SW'(1);
  end

  assign stall_hit = (rep_d == SW'(STALL_K));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= '0;
      rep_q  <= '0;
    end else if (state_q == IDLE && start) begin
      last_q <= '0;
      rep_q  <= '0;
    end else if (sample) begin
      last_q <= alive;
      rep_q  <= rep_d;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // Priority: WIN > ALL_ZERO > STALL > TIMEOUT.
  always_comb begin
    fin   = 1'b0;
    st_d  = ST_WIN;
    idx_d = low_idx;
    val_d = low_val;
    if (is_onehot) begin
      fin = 1'b1;
    end else if (is_zero) begin
      fin   = 1'b1;
      st_d  = ST_ALL_ZERO;
      idx_d = '0;
      val_d = '0;
    end else if (stall_hit) begin
      fin  = 1'b1;
      st_d = ST_STALL;
    end else if (to_hit) begin
      fin  = 1'b1;
      st_d = ST_TIMEOUT;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (sample && fin) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= ST_WIN;
      idx_q   <= '0;
      val_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start)
        iter_q <= '0;
      else if (sample)
        iter_q <= iter_nxt;
      if (sample && fin) begin
        st_q  <= st_d;
        idx_q <= idx_d;
        val_q <= val_d;
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign res_valid = (state_q == DONE);
  assign win_idx   = idx_q;
  assign win_val   = val_q;
  assign status    = st_q;
  assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_maxnet_term_ctrl.sv
// Self-checking bench for maxnet_term_ctrl against a behavioural model.
// Honours STALL_DETECT_EN when compiled with it.
module tb_maxnet_term_ctrl;

  localparam int N       = 4;
  localparam int W       = 16;
  localparam int MAX_IT  = 6;
  localparam int STALL_K = 3;
  localparam int IW      = 2;
  localparam int ITW     = 3;
`ifdef STALL_DETECT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           in_valid;
  logic [N*W-1:0] x_bus;
  logic [N-1:0]   alive;
  logic           busy;
  logic           res_valid;
  logic           res_ready;
  logic [IW-1:0]  win_idx;
  logic [W-1:0]   win_val;
  logic [1:0]     status;
  logic [ITW-1:0] iter_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int           m_k;
  int           m_rep;
  logic [N-1:0] m_last;
  bit           m_done;
  int           m_st;
  int           m_idx;
  logic [W-1:0] m_val;

  always #5 clk = ~clk;

  maxnet_term_ctrl #(
    .N(N), .W(W), .MAX_IT(MAX_IT), .STALL_K(STALL_K)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .x_bus     (x_bus),
    .alive     (alive),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .win_idx   (win_idx),
    .win_val   (win_val),
    .status    (status),
    .iter_cnt  (iter_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [N-1:0] a);
    for (int i = 0; i < N; i++)
      if (a[i]) return i;
    return 0;
  endfunction

  task automatic model_sample(input logic [N-1:0] a,
                              input logic [N*W-1:0] xb);
    int lo;
    m_k++;
    if (a == m_last) m_rep++;
    else m_rep = 0;
    m_last = a;
    lo = lowest(a);
    if ($countones(a) == 1) begin
      m_done = 1; m_st = 0; m_idx = lo; m_val = xb[lo*W +: W];
    end else if (a == '0) begin
      m_done = 1; m_st = 1; m_idx = 0; m_val = '0;
    end else if (STALL_EN && m_rep >= STALL_K) begin
      m_done = 1; m_st = 3; m_idx = lo; m_val = xb[lo*W +: W];
    end else if (m_k == MAX_IT) begin
      m_done = 1; m_st = 2; m_idx = lo; m_val = xb[lo*W +: W];
    end
  endtask

  task automatic begin_run();
    start = 1'b1;
    step();
    start = 1'b0;
    m_k = 0; m_rep = 0; m_last = '0; m_done = 0;
  endtask

  task automatic feed(input bit v, input logic [N-1:0] a,
                      input logic [N*W-1:0] xb);
    in_valid = v;
    alive    = a;
    x_bus    = xb;
    step();
    in_valid = 1'b0;
    if (v && !m_done) model_sample(a, xb);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  function automatic logic [N*W-1:0] rand_xb();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({busy, res_valid, win_idx, win_val, status, iter_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b rv=%b idx=%0d val=%h st=%0d it=%0d want all 0",
               busy, res_valid, win_idx, win_val, status, iter_cnt);
    end
    rst_n = 1'b1;
    feed(1'b1, 4'b0010, rand_xb());
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_valid got busy=%b rv=%b want 0 0", busy, res_valid);
    end
  endtask

  task automatic test_win();
    logic [N*W-1:0] xb;
    xb = rand_xb();
    xb[2*W +: W] = 16'h0055;
    begin_run();
    checks++;
    if (busy !== 1'b1 || iter_cnt !== 3'd0) begin
      errors++;
      $display("FAIL run_entry got busy=%b it=%0d want 1 0", busy, iter_cnt);
    end
    feed(1'b1, 4'b0100, xb);
    checks++;
    if (res_valid !== 1'b1 || status !== 2'd0 || win_idx !== 2'd2 ||
        win_val !== 16'h0055 || iter_cnt !== 3'd1) begin
      errors++;
      $display("FAIL win got rv=%b st=%0d idx=%0d val=%h it=%0d want 1 0 2 0055 1",
               res_valid, status, win_idx, win_val, iter_cnt);
    end
    accept();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL win_accept got rv=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_all_zero();
    begin_run();
    feed(1'b1, 4'b1111, rand_xb());
    feed(1'b1, 4'b0111, rand_xb());
    checks++;
    if (res_valid !== 1'b0 || iter_cnt !== 3'd2) begin
      errors++;
      $display("FAIL zero_midrun got rv=%b it=%0d want 0 2", res_valid, iter_cnt);
    end
    feed(1'b1, 4'b0000, rand_xb());
    checks++;
    if (res_valid !== 1'b1 || status !== 2'd1 || win_idx !== 2'd0 ||
        win_val !== 16'h0 || iter_cnt !== 3'd3) begin
      errors++;
      $display("FAIL all_zero got rv=%b st=%0d idx=%0d val=%h it=%0d want 1 1 0 0 3",
               res_valid, status, win_idx, win_val, iter_cnt);
    end
    accept();
  endtask

  task automatic test_timeout();
    logic [N*W-1:0] xb;
    begin_run();
    for (int i = 0; i < MAX_IT; i++) begin
      xb = rand_xb();
      feed(1'b1, (i % 2 == 0) ? 4'b0011 : 4'b1011, xb);
    end
    checks++;
    if (res_valid !== 1'b1 || status !== 2'd2 || win_idx !== 2'd0 ||
        win_val !== xb[W-1:0] || iter_cnt !== 3'(MAX_IT)) begin
      errors++;
      $display("FAIL timeout got rv=%b st=%0d idx=%0d val=%h it=%0d want 1 2 0 %h %0d",
               res_valid, status, win_idx, win_val, iter_cnt, xb[W-1:0], MAX_IT);
    end
    accept();
  endtask

  task automatic test_hold();
    logic [N*W-1:0] xb;
    xb = rand_xb();
    begin_run();
    feed(1'b1, 4'b1000, xb);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      feed(1'b1, 4'b0001, rand_xb());
      start = 1'b0;
      checks++;
      if (res_valid !== 1'b1 || busy !== 1'b0 || status !== 2'd0 ||
          win_idx !== 2'd3 || win_val !== xb[3*W +: W] || iter_cnt !== 3'd1) begin
        errors++;
        $display("FAIL hold_%0d got rv=%b busy=%b st=%0d idx=%0d val=%h it=%0d",
                 c, res_valid, busy, status, win_idx, win_val, iter_cnt);
      end
    end
    accept();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got rv=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_gaps_and_abort();
    begin_run();
    feed(1'b1, 4'b1100, rand_xb());
    feed(1'b0, 4'b0001, rand_xb());
    feed(1'b0, 4'b0000, rand_xb());
    feed(1'b0, 4'b0100, rand_xb());
    feed(1'b1, 4'b1010, rand_xb());
    checks++;
    if (iter_cnt !== 3'd2 || busy !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL gaps got it=%0d busy=%b rv=%b want 2 1 0",
               iter_cnt, busy, res_valid);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({busy, res_valid, win_idx, win_val, status, iter_cnt} !== '0) begin
      errors++;
      $display("FAIL abort got busy=%b rv=%b idx=%0d val=%h st=%0d it=%0d want all 0",
               busy, res_valid, win_idx, win_val, status, iter_cnt);
    end
  endtask

  task automatic test_stall();
    logic [N*W-1:0] xb;
    int exp_st, exp_it;
    exp_st = STALL_EN ? 3 : 2;
    exp_it = STALL_EN ? STALL_K + 1 : MAX_IT;
    begin_run();
    for (int i = 0; i < MAX_IT + 2 && !res_valid; i++) begin
      xb = rand_xb();
      feed(1'b1, 4'b0110, xb);
    end
    checks++;
    if (res_valid !== 1'b1 || status !== 2'(exp_st) || win_idx !== 2'd1 ||
        win_val !== xb[W +: W] || iter_cnt !== 3'(exp_it)) begin
      errors++;
      $display("FAIL stall got rv=%b st=%0d idx=%0d val=%h it=%0d want 1 %0d 1 %h %0d",
               res_valid, status, win_idx, win_val, iter_cnt,
               exp_st, xb[W +: W], exp_it);
    end
    accept();
  endtask

  task automatic test_random();
    logic [N-1:0] a;
    int r, cyc;
    for (int run = 0; run < 40; run++) begin
      begin_run();
      a = 4'b0011;
      cyc = 0;
      while (!m_done && cyc < 4 * MAX_IT) begin
        r = $urandom_range(0, 9);
        if (r >= 5 && r < 9) begin
          do a = 4'($urandom()); while ($countones(a) < 2);
        end else if (r == 9) begin
          a = 4'($urandom());
        end
        feed($urandom_range(0, 3) != 0, a, rand_xb());
        cyc++;
        checks++;
        if (res_valid !== m_done || busy !== !m_done ||
            iter_cnt !== 3'(m_k)) begin
          errors++;
          $display("FAIL rand_run%0d_c%0d got rv=%b busy=%b it=%0d want %b %b %0d",
                   run, cyc, res_valid, busy, iter_cnt, m_done, !m_done, m_k);
        end
      end
      checks++;
      if (!m_done || status !== 2'(m_st) || win_idx !== 2'(m_idx) ||
          win_val !== m_val) begin
        errors++;
        $display("FAIL rand_result%0d got st=%0d idx=%0d val=%h want done=1 %0d %0d %h",
                 run, status, win_idx, win_val, m_st, m_idx, m_val);
      end
      for (int d = $urandom_range(0, 2); d > 0; d--) begin
        start = 1'b1;
        step();
      end
      start = 1'b0;
      accept();
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_accept%0d got rv=%b busy=%b want 0 0",
                 run, res_valid, busy);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    x_bus     = '0;
    alive     = '0;
    res_ready = 1'b0;
    test_reset();
    test_win();
    test_all_zero();
    test_timeout();
    test_hold();
    test_gaps_and_abort();
    test_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
